// File: rtl/ram_pkg.sv
// ram_pkg: default geometry shared by register-array memories.
package ram_pkg;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 4;
endpackage

// File: rtl/ram.sv
// ram: dual-port register-array RAM, write-first on address collision, one-cycle clear on reset.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  hit;
  assign hit  = we && wr_addr == rd_addr;
  assign dout = dout_q;
  always_comb dout_d = !re ? dout_q : hit ? din : mem_q[rd_addr];
  // Register array rather than a RAM primitive so every word can clear in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      if (we) mem_q[wr_addr] <= din;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram; expected read data is queued at drive time and checked after the edge.
module tb_ram;
  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  logic [7:0] din, dout;
  logic       clk, rst, we, re;
  logic [3:0] wr_addr, rd_addr;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;

  ram dut (
    .din(din), .dout(dout), .clk(clk), .rst(rst), .we(we), .re(re),
    .wr_addr(wr_addr), .rd_addr(rd_addr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic op(input string nm, input logic r, input logic w, input logic rd,
                    input logic [3:0] wa, input logic [3:0] ra, input logic [7:0] d,
                    input logic chk, input logic [7:0] ex);
    exp_t e;
    rst = r; we = w; re = rd; wr_addr = wa; rd_addr = ra; din = d;
    if (chk) begin
      e.nm = nm;
      e.v  = ex;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (dout !== e.v) begin
        errors++;
        $display("FAIL %s: dout=%02h expected=%02h", e.nm, dout, e.v);
      end
    end
  endtask

  task automatic idle();
    op("idle", 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic test_reset();
    op("reset_dout", 1, 0, 0, 0, 0, 8'h00, 1, 8'h00);
    op("read_after_reset", 0, 0, 1, 0, 5, 8'h00, 1, 8'h00);
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < 16; i++) op("fill", 0, 1, 0, 4'(i), 0, 8'(8'h10 + i), 0, 8'h00);
    for (int i = 0; i < 16; i++) op("readback", 0, 0, 1, 0, 4'(i), 8'h00, 1, 8'(8'h10 + i));
  endtask

  task automatic test_we_low();
    op("wr_a5", 0, 1, 0, 3, 0, 8'hA5, 0, 8'h00);
    op("we_low", 0, 0, 0, 3, 0, 8'hFF, 0, 8'h00);
    op("we_low_read", 0, 0, 1, 0, 3, 8'hFF, 1, 8'hA5);
  endtask

  task automatic test_write_first();
    op("write_first", 0, 1, 1, 7, 7, 8'h3C, 1, 8'h3C);
    op("write_first_reread", 0, 0, 1, 0, 7, 8'h00, 1, 8'h3C);
  endtask

  task automatic test_hold();
    op("hold_read", 0, 0, 1, 0, 2, 8'h00, 1, 8'h12);
    for (int i = 0; i < 3; i++) op("hold", 0, 0, 0, 0, 4'(9 + i), 8'h00, 1, 8'h12);
  endtask

  task automatic test_independent();
    op("indep_read", 0, 1, 1, 9, 4, 8'h99, 1, 8'h14);
    op("indep_write", 0, 0, 1, 0, 9, 8'h00, 1, 8'h99);
    op("indep_max", 0, 1, 1, 15, 0, 8'hE1, 1, 8'h10);
    op("indep_max_read", 0, 0, 1, 0, 15, 8'h00, 1, 8'hE1);
  endtask

  task automatic test_reset_mid();
    op("reset_prio", 1, 1, 1, 1, 0, 8'h77, 1, 8'h00);
    for (int i = 0; i < 16; i++) op("cleared", 0, 0, 1, 0, 4'(i), 8'h00, 1, 8'h00);
    op("resume_wr", 0, 1, 0, 6, 0, 8'h5A, 0, 8'h00);
    op("resume_rd", 0, 0, 1, 0, 6, 8'h00, 1, 8'h5A);
  endtask

  initial begin
    rst = 1; we = 0; re = 0; wr_addr = 0; rd_addr = 0; din = 0;
    idle();
    test_reset();
    test_fill_read();
    test_we_low();
    test_write_first();
    test_hold();
    test_independent();
    test_reset_mid();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH (16), number of words.
REQ-004 Port order SHALL be din, dout, clk, rst, we, re, wr_addr, rd_addr, so positional instantiation works.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 din  input  DATA_WIDTH  write data.
REQ-008 dout  output  DATA_WIDTH  registered read data.
REQ-009 we  input  1  write enable, active-high.
REQ-010 re  input  1  read enable, active-high.
REQ-011 wr_addr  input  ADDR_WIDTH  write address.
REQ-012 rd_addr  input  ADDR_WIDTH  read address.

Function
REQ-013 Storage SHALL be DEPTH words of DATA_WIDTH bits, with independent write and read ports in the same clock domain.
REQ-014 Write: at a rising edge with rst=0 and we=1, mem[wr_addr] SHALL take din, visible to reads from the next edge.
REQ-015 we=0 SHALL leave memory unchanged, regardless of din and wr_addr.
REQ-016 Read: at a rising edge with rst=0 and re=1, dout SHALL take mem[rd_addr]; latency is 1 clock from sampled re/rd_addr to valid dout.
REQ-017 re=0 SHALL hold dout at its previous value.
REQ-018 Read and write to the same address on the same edge SHALL be write-first: dout takes din.
REQ-019 Read and write to different addresses on the same edge SHALL be fully independent.
REQ-020 Addresses SHALL cover the full range 0..DEPTH-1 with no wrap or aliasing; out-of-range values are impossible when DEPTH=2**ADDR_WIDTH.
REQ-021 X-free: with no write since reset, any read SHALL return 0.

Reset
REQ-022 At a rising edge with rst=1, dout SHALL become 0.
REQ-023 At a rising edge with rst=1, every memory word SHALL become 0 in that single cycle.
REQ-024 rst SHALL take priority over we and re; a write or read in a reset cycle is discarded.
REQ-025 Reset asserted mid-sequence SHALL discard all prior contents; operation resumes on the first edge with rst=0.

Structure
REQ-026 A single flat module is sufficient; no sub-module is required.
REQ-027 No shared package is required; DATA_WIDTH and ADDR_WIDTH defaults MAY move to a shared package if other memories reuse them.
REQ-028 Memory SHALL be a register array; no vendor RAM primitives, because of the one-cycle clear.

Verification
REQ-029 Reset, then re=1 with rd_addr=5 -> dout=0x00 one clock later.
REQ-030 Write 16 distinct values (addr i <- 0x10+i), then read addresses 0..15 back-to-back -> dout sequence 0x10..0x1F, each one clock after its address.
REQ-031 Write 0xA5 to addr 3, then present din=0xFF, wr_addr=3, we=0; read addr 3 -> 0xA5.
REQ-032 Same edge: we=1, wr_addr=7, din=0x3C, re=1, rd_addr=7 -> dout=0x3C next clock; later plain read of 7 -> 0x3C.
REQ-033 Read addr 2 (0x12), then re=0 for 3 cycles while rd_addr changes -> dout stays 0x12.
REQ-034 Fill memory, assert rst for one cycle with we=1 and re=1 -> dout=0, no write occurs, and subsequent reads of all 16 addresses return 0.
